// File: rtl/heartbeat_monitor.sv
// Multi-channel heartbeat supervisor: synchronises each heartbeat line, qualifies
// liveness over a run of edges and flags loss after an edge-free timeout.
module heartbeat_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 24,
    parameter int TIMEOUT     = 1000000,
    parameter int ALIVE_EDGES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] hb_in,
    input  logic [NUM_CH-1:0] clr_lost,
    output logic [NUM_CH-1:0] alive,
    output logic [NUM_CH-1:0] lost_sticky,
    output logic              any_alive,
    output logic              all_alive,
    output logic              irq
);

    localparam int ECNT_W = $clog2(ALIVE_EDGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [ECNT_W-1:0] ECNT_DONE = ECNT_W'(ALIVE_EDGES);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ACQ   = 2'd1,
        ST_ALIVE = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [NUM_CH-1:0]      prev_q;
    logic [NUM_CH-1:0]      edge_s;
    state_e                 state_q [NUM_CH];
    state_e                 state_d [NUM_CH];
    logic [CNT_W-1:0]       cnt_q [NUM_CH];
    logic [CNT_W-1:0]       cnt_d [NUM_CH];
    logic [ECNT_W-1:0]      ecnt_q [NUM_CH];
    logic [ECNT_W-1:0]      ecnt_d [NUM_CH];
    logic [NUM_CH-1:0]      alive_q, alive_d;
    logic [NUM_CH-1:0]      lost_q, lost_d;
    logic [NUM_CH-1:0]      loss_s;
    logic                   irq_q;

    // Synchroniser chain plus previous-sample flop; a 1 at reset release reads as an edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c] <= {SYNC_STAGES{1'b0}};
            end
            prev_q <= {NUM_CH{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], hb_in[c]};
                prev_q[c] <= sync_q[c][SYNC_STAGES-1];
            end
        end
    end

    // Edge detect on the synchronised line.
    always_comb begin
        edge_s = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            edge_s[c] = sync_q[c][SYNC_STAGES-1] ^ prev_q[c];
        end
    end

    // Per-channel qualification FSM; an edge always beats a same-cycle timeout.
    always_comb begin
        loss_s = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            ecnt_d[c]  = ecnt_q[c];
            alive_d[c] = alive_q[c];
            if (!en[c]) begin
                state_d[c] = ST_OFF;
                cnt_d[c]   = {CNT_W{1'b0}};
                ecnt_d[c]  = {ECNT_W{1'b0}};
                alive_d[c] = 1'b0;
            end else begin
                case (state_q[c])
                    ST_OFF: begin
                        state_d[c] = ST_ACQ;
                        cnt_d[c]   = {CNT_W{1'b0}};
                        ecnt_d[c]  = {ECNT_W{1'b0}};
                        alive_d[c] = 1'b0;
                    end
                    ST_ACQ: begin
                        if (edge_s[c]) begin
                            cnt_d[c] = {CNT_W{1'b0}};
                            if ((ecnt_q[c] + ECNT_W'(1)) == ECNT_DONE) begin
                                state_d[c] = ST_ALIVE;
                                alive_d[c] = 1'b1;
                                ecnt_d[c]  = {ECNT_W{1'b0}};
                            end else begin
                                ecnt_d[c] = ecnt_q[c] + ECNT_W'(1);
                            end
                        end else if (cnt_q[c] < CNT_MAX) begin
                            cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        end else begin
                            ecnt_d[c] = {ECNT_W{1'b0}};
                        end
                    end
                    ST_ALIVE: begin
                        if (edge_s[c]) begin
                            cnt_d[c] = {CNT_W{1'b0}};
                        end else if (cnt_q[c] < CNT_MAX) begin
                            cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        end else begin
                            state_d[c] = ST_ACQ;
                            alive_d[c] = 1'b0;
                            ecnt_d[c]  = {ECNT_W{1'b0}};
                            loss_s[c]  = 1'b1;
                        end
                    end
                    default: begin
                        state_d[c] = ST_OFF;
                        cnt_d[c]   = {CNT_W{1'b0}};
                        ecnt_d[c]  = {ECNT_W{1'b0}};
                        alive_d[c] = 1'b0;
                    end
                endcase
            end
        end
        // A new loss overrides a simultaneous clear.
        lost_d = (lost_q & ~clr_lost) | loss_s;
    end

    // Channel state, flags and the shared interrupt pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_OFF;
                cnt_q[c]   <= {CNT_W{1'b0}};
                ecnt_q[c]  <= {ECNT_W{1'b0}};
            end
            alive_q <= {NUM_CH{1'b0}};
            lost_q  <= {NUM_CH{1'b0}};
            irq_q   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                ecnt_q[c]  <= ecnt_d[c];
            end
            alive_q <= alive_d;
            lost_q  <= lost_d;
            irq_q   <= |loss_s;
        end
    end

    assign alive       = alive_q;
    assign lost_sticky = lost_q;
    assign irq         = irq_q;
    assign any_alive   = |alive_q;
    assign all_alive   = (|en) & (&(alive_q | ~en));

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Bench for heartbeat_monitor: directed vector table, reset corner cases and
// randomised heartbeats compared against a behavioural model.
module tb_heartbeat_monitor;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int AE = 2;
    localparam int SS = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         nrst;
    logic [N-1:0] en, hb, clr, alive, lost;
    logic         any_s, all_s, irq;

    logic         nrst1;
    logic [N-1:0] en1, hb1, clr1, alive1, lost1;
    logic         any1, all1, irq1;

    heartbeat_monitor #(.NUM_CH(N), .CNT_W(CW), .TIMEOUT(T), .ALIVE_EDGES(AE), .SYNC_STAGES(SS)) dut (
        .clk(clk), .nrst(nrst), .en(en), .hb_in(hb), .clr_lost(clr),
        .alive(alive), .lost_sticky(lost), .any_alive(any_s), .all_alive(all_s), .irq(irq)
    );

    heartbeat_monitor #(.NUM_CH(N), .CNT_W(CW), .TIMEOUT(T), .ALIVE_EDGES(1), .SYNC_STAGES(SS)) dut1 (
        .clk(clk), .nrst(nrst1), .en(en1), .hb_in(hb1), .clr_lost(clr1),
        .alive(alive1), .lost_sticky(lost1), .any_alive(any1), .all_alive(all1), .irq(irq1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: raw-sample history, per-channel liveness bookkeeping.
    logic [N-1:0] hist [0:SS];
    bit           m_on    [N];
    bit           m_alive [N];
    int           m_edges [N];
    int           m_idle  [N];
    logic [N-1:0] m_lost;
    logic         m_irq;

    function automatic void model_reset();
        for (int j = 0; j <= SS; j++) hist[j] = '0;
        for (int i = 0; i < N; i++) begin
            m_on[i] = 1'b0; m_alive[i] = 1'b0; m_edges[i] = 0; m_idle[i] = 0;
        end
        m_lost = '0;
        m_irq  = 1'b0;
    endfunction

    function automatic logic [N-1:0] m_alive_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_alive[i];
        return v;
    endfunction

    function automatic void model_step(input logic [N-1:0] e, input logic [N-1:0] h, input logic [N-1:0] c);
        logic [N-1:0] edg, lostnow;
        // The decision at a clock sees the raw line as sampled SS and SS+1 clocks earlier.
        edg = hist[SS-1] ^ hist[SS];
        for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = h;
        lostnow = '0;
        for (int i = 0; i < N; i++) begin
            if (!e[i]) begin
                m_on[i] = 1'b0; m_alive[i] = 1'b0; m_edges[i] = 0; m_idle[i] = 0;
            end else if (!m_on[i]) begin
                m_on[i] = 1'b1; m_edges[i] = 0; m_idle[i] = 0;
            end else if (edg[i]) begin
                m_idle[i] = 0;
                if (!m_alive[i]) begin
                    m_edges[i]++;
                    if (m_edges[i] == AE) begin
                        m_alive[i] = 1'b1;
                        m_edges[i] = 0;
                    end
                end
            end else if (m_idle[i] < T) begin
                m_idle[i]++;
            end else begin
                m_edges[i] = 0;
                if (m_alive[i]) begin
                    m_alive[i] = 1'b0;
                    lostnow[i] = 1'b1;
                end
            end
        end
        m_lost = (m_lost & ~c) | lostnow;
        m_irq  = |lostnow;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare just after the edge.
    task automatic tick(input logic [N-1:0] e, input logic [N-1:0] h, input logic [N-1:0] c);
        logic [N-1:0] ma;
        en = e; hb = h; clr = c;
        @(posedge clk);
        model_step(e, h, c);
        #1;
        ma = m_alive_vec();
        chk("model alive", 32'(alive), 32'(ma));
        chk("model lost_sticky", 32'(lost), 32'(m_lost));
        chk("model irq", 32'(irq), 32'(m_irq));
        chk("model any_alive", 32'(any_s), 32'(|ma));
        chk("model all_alive", 32'(all_s), 32'((|e) & (&(ma | ~e))));
    endtask

    typedef struct {
        int       n;
        logic [3:0] en;
        logic [3:0] hb;
        logic [3:0] clr;
        logic [3:0] alive;
        logic [3:0] lost;
        logic     irq;
        logic     any;
        logic     all;
    } vec_t;

    vec_t tbl [28];
    int   gap [N];

    initial begin
        // n, en, hb, clr | alive, lost, irq, any, all  (checked on every clock of the row)
        tbl[0]  = '{1,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{16, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1,  4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{21, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{8,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1,  4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{16, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1,  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1,  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1,  4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{7,  4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{2,  4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{6,  4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{2,  4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1,  4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[22] = '{1,  4'b1011, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[23] = '{4,  4'b1011, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[24] = '{8,  4'b1011, 4'b1000, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[25] = '{3,  4'b1011, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[26] = '{1,  4'b1011, 4'b0000, 4'b0000, 4'b1000, 4'b0011, 1'b1, 1'b1, 1'b0};
        tbl[27] = '{1,  4'b1011, 4'b0000, 4'b0000, 4'b1000, 4'b0011, 1'b0, 1'b1, 1'b0};

        nrst = 1'b0; en = '0; hb = '0; clr = '0;
        nrst1 = 1'b0; en1 = '0; hb1 = '0; clr1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset alive", 32'(alive), 32'(0));
        chk("reset lost_sticky", 32'(lost), 32'(0));
        chk("reset irq", 32'(irq), 32'(0));
        chk("reset any_alive", 32'(any_s), 32'(0));
        chk("reset all_alive", 32'(all_s), 32'(0));
        nrst = 1'b1;

        for (int i = 0; i < 28; i++) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                tick(tbl[i].en, tbl[i].hb, tbl[i].clr);
                chk($sformatf("row%0d alive", i), 32'(alive), 32'(tbl[i].alive));
                chk($sformatf("row%0d lost_sticky", i), 32'(lost), 32'(tbl[i].lost));
                chk($sformatf("row%0d irq", i), 32'(irq), 32'(tbl[i].irq));
                chk($sformatf("row%0d any_alive", i), 32'(any_s), 32'(tbl[i].any));
                chk($sformatf("row%0d all_alive", i), 32'(all_s), 32'(tbl[i].all));
            end
        end

        // Asynchronous reset between clock edges while channels are alive.
        repeat (2) tick(4'b1011, 4'b1000, 4'b0000);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("async rst alive", 32'(alive), 32'(0));
        chk("async rst lost_sticky", 32'(lost), 32'(0));
        chk("async rst irq", 32'(irq), 32'(0));
        chk("async rst any_alive", 32'(any_s), 32'(0));
        model_reset();
        en = 4'b0001; hb = 4'b0001; clr = '0;
        en1 = 4'b0001; hb1 = 4'b0001; clr1 = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        nrst1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(4'b0001, 4'b0001, 4'b0000);
            chk($sformatf("single-edge alive clk%0d", k), 32'(alive1), 32'((k == 3) ? 4'b0001 : 4'b0000));
        end
        chk("single-edge any_alive", 32'(any1), 32'(1));
        chk("single-edge all_alive", 32'(all1), 32'(1));
        chk("single-edge lost_sticky", 32'(lost1), 32'(0));
        chk("single-edge irq", 32'(irq1), 32'(0));
        en1 = '0;

        // Randomised heartbeats with gaps straddling the timeout.
        for (int i = 0; i < N; i++) gap[i] = $urandom_range(1, 22);
        en = 4'b1111;
        for (int t = 0; t < 4000; t++) begin
            logic [N-1:0] h, e, c;
            h = hb; e = en; c = '0;
            for (int i = 0; i < N; i++) begin
                gap[i]--;
                if (gap[i] <= 0) begin
                    h[i] = ~h[i];
                    gap[i] = $urandom_range(1, 22);
                end
            end
            if ($urandom_range(0, 79) == 0) e[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) c = N'($urandom_range(0, 15));
            tick(e, h, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/heartbeat_monitor.md
Name: heartbeat_monitor

Overview:
Multi-channel heartbeat supervisor. It is the parametrised successor of the single-channel SWIPT heartbeat checker. Each channel watches a toggling heartbeat line from another domain or board: it synchronises the line, detects edges, qualifies liveness over N edges, and declares loss after a programmable edge-free timeout. It sits between the external heartbeat pins and the control/status logic, and provides per-channel alive flags, sticky loss flags and a loss interrupt pulse.

Parameters:
NUM_CH, 4, number of independent heartbeat channels (>=1)
CNT_W, 24, timeout counter width; TIMEOUT < 2**CNT_W required
TIMEOUT, 1000000, edge-free cycle limit; a channel is lost after TIMEOUT+1 consecutive edge-free cycles
ALIVE_EDGES, 2, consecutive edges, each within TIMEOUT of the previous, needed to declare alive (>=1)
SYNC_STAGES, 2, synchroniser flops per heartbeat input (>=2)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
en  in  NUM_CH  per-channel enable
hb_in  in  NUM_CH  raw heartbeat lines (asynchronous)
clr_lost  in  NUM_CH  per-channel clear of lost_sticky (single-cycle or level)
alive  out  NUM_CH  channel qualified alive
lost_sticky  out  NUM_CH  set on ALIVE->loss, held until clr_lost
any_alive  out  1  OR of alive
all_alive  out  1  AND of alive over enabled channels; 0 when no channel is enabled
irq  out  1  one-cycle pulse when any channel is lost

Behaviour:
- Reset (nrst low, async): all sync flops, prev-sample flops, counters, edge counts, alive, lost_sticky and irq go to 0. FSMs go to OFF. Reset released mid-operation restarts cleanly.
- Per channel: SYNC_STAGES flop chain, then prev flop. edge = sync_out XOR prev.
- A level of 1 present at reset release counts as one edge.
- Latency: the first clk edge sampling a toggle is edge 1. The FSM reacts on edge SYNC_STAGES+1 (edge 3 with default).
- Per-channel state: cnt[CNT_W], ecnt (width clog2(ALIVE_EDGES+1)), FSM {OFF, ACQ, ALIVE}.
- OFF: cnt=0, ecnt=0, alive=0. Goes to ACQ when en=1.
- Any state with en=0: OFF next edge. alive drops, no loss flagged, no irq.
- ACQ, edge:
  - cnt<=0, ecnt<=ecnt+1.
  - If ecnt+1==ALIVE_EDGES: go to ALIVE, alive<=1, ecnt<=0.
- ACQ, no edge:
  - cnt<TIMEOUT: cnt<=cnt+1.
  - cnt==TIMEOUT: ecnt<=0 (qualification window expired); cnt holds at TIMEOUT, no wrap.
- ALIVE, edge: cnt<=0.
- ALIVE, no edge:
  - cnt<TIMEOUT: cnt<=cnt+1.
  - cnt==TIMEOUT: go to ACQ. alive<=0, ecnt<=0, cnt holds, lost_sticky<=1, irq<=1 for exactly one cycle.
- Simultaneous events:
  - Edge and timeout in the same cycle: the edge wins (no loss).
  - clr_lost and a new loss on the same channel in the same cycle: set wins.
  - Multiple channels lost in the same cycle: a single irq pulse.
- Counters never wrap; cnt is never incremented past TIMEOUT.
- any_alive and all_alive are combinational from the alive registers and en.

Test Plan:
- Use TIMEOUT=16, ALIVE_EDGES=2, SYNC_STAGES=2, NUM_CH=4 for all scenarios.
- Qualify: en=4'b0001; toggle hb_in[0] every 8 cycles -> alive[0]=1 on the 3rd clk after the second toggle is sampled; any_alive=1, all_alive=1.
- Timeout: after alive[0]=1, stop toggling -> alive[0] falls after 17 edge-free cycles. irq high for exactly 1 cycle on that edge; lost_sticky[0]=1.
- Window expiry: 1 toggle, wait 20 cycles, 1 toggle -> alive stays 0. One further toggle within 16 cycles -> alive=1.
- Clear/set race: hold clr_lost[0]=1 across the loss cycle -> lost_sticky[0]=1 at that cycle. Pulse clr_lost[0] later -> 0.
- Disable and multi-channel: all 4 channels alive; drop en[2] -> alive[2]=0 next edge, no irq, lost_sticky[2]=0, all_alive=1. Stop ch0 and ch1 in the same cycle -> single irq pulse; lost_sticky=4'b0011.
- Async reset mid-count: assert nrst low between clk edges while alive -> all outputs 0 immediately. After release with hb_in[0]=1 and ALIVE_EDGES=1 -> alive[0]=1 on the 3rd clk.
